// File: rtl/grf_mp.sv
// Multi-port general register file: NUM_RD read ports, two write ports with
// write-to-read bypass, and a per-register busy scoreboard. Define GRF_TRACE_EN for write tracing.
module grf_mp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    output logic [NUM_RD*DATA_W-1:0] rdata,
    output logic [NUM_RD-1:0]        rbusy,
    input  logic                     we0,
    input  logic [ADDR_W-1:0]        waddr0,
    input  logic [DATA_W-1:0]        wdata0,
    input  logic [31:0]              wpc0,
    input  logic                     we1,
    input  logic [ADDR_W-1:0]        waddr1,
    input  logic [DATA_W-1:0]        wdata1,
    input  logic [31:0]              wpc1,
    input  logic                     bset,
    input  logic [ADDR_W-1:0]        baddr
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;
    logic              wr0_en;
    logic              wr1_en;

    assign wr0_en = we0 && (waddr0 != '0);
    assign wr1_en = we1 && (waddr1 != '0);

    // Port 1 is applied last so it wins a same-address collision.
    always_comb begin
        regs_d = regs_q;
        if (wr0_en) regs_d[waddr0] = wdata0;
        if (wr1_en) regs_d[waddr1] = wdata1;
    end

    // Set is applied after the clears: a newly issued producer supersedes the retiring one.
    always_comb begin
        busy_d = busy_q;
        if (wr0_en) busy_d[waddr0] = 1'b0;
        if (wr1_en) busy_d[waddr1] = 1'b0;
        if (bset && (baddr != '0)) busy_d[baddr] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic              hit0;
        logic              hit1;

        assign ra   = raddr[k*ADDR_W +: ADDR_W];
        assign hit0 = !reset && wr0_en && (waddr0 == ra);
        assign hit1 = !reset && wr1_en && (waddr1 == ra);

        always_comb begin
            rdata[k*DATA_W +: DATA_W] = '0;
            rbusy[k]                  = 1'b0;
            if (ra != '0) begin
                if (hit1)      rdata[k*DATA_W +: DATA_W] = wdata1;
                else if (hit0) rdata[k*DATA_W +: DATA_W] = wdata0;
                else           rdata[k*DATA_W +: DATA_W] = regs_q[ra];
                rbusy[k] = !reset && busy_q[ra] && !hit0 && !hit1;
            end
        end
    end

`ifdef GRF_TRACE_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (wr0_en && !(wr1_en && (waddr1 == waddr0)))
                $display("@%h: $%d <= %h", wpc0, waddr0, wdata0);
            if (wr1_en)
                $display("@%h: $%d <= %h", wpc1, waddr1, wdata1);
        end
    end
`else
    logic unused_trace_pc;
    assign unused_trace_pc = ^{wpc0, wpc1};
`endif

endmodule

// File: tb/tb_grf_mp.sv
// Bench for grf_mp: reference model of register contents and busy bits checked every cycle,
// plus literal expectations for reset, bypass, port conflict, r0, scoreboard race and a narrow build.
module tb_grf_mp;

    logic        clk = 1'b0;
    logic        reset;

    logic [9:0]  raddr;
    logic [63:0] rdata;
    logic [1:0]  rbusy;
    logic        we0, we1, bset;
    logic [4:0]  waddr0, waddr1, baddr;
    logic [31:0] wdata0, wdata1, wpc0, wpc1;

    logic [8:0]  p_raddr;
    logic [47:0] p_rdata;
    logic [2:0]  p_rbusy;
    logic        p_we0, p_we1, p_bset;
    logic [2:0]  p_waddr0, p_waddr1, p_baddr;
    logic [15:0] p_wdata0, p_wdata1;
    logic [31:0] p_wpc0, p_wpc1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    grf_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) u0 (
        .clk(clk), .reset(reset), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0), .wpc0(wpc0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1), .wpc1(wpc1),
        .bset(bset), .baddr(baddr)
    );

    grf_mp #(.DATA_W(16), .ADDR_W(3), .NUM_RD(3)) u1 (
        .clk(clk), .reset(reset), .raddr(p_raddr), .rdata(p_rdata), .rbusy(p_rbusy),
        .we0(p_we0), .waddr0(p_waddr0), .wdata0(p_wdata0), .wpc0(p_wpc0),
        .we1(p_we1), .waddr1(p_waddr1), .wdata1(p_wdata1), .wpc1(p_wpc1),
        .bset(p_bset), .baddr(p_baddr)
    );

    // Reference model: architectural register values and outstanding producers.
    logic [31:0] m_mem  [32];
    bit          m_busy [32];
    bit          model_ok = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                m_mem[i]  = '0;
                m_busy[i] = 1'b0;
            end
            model_ok = 1'b1;
        end else begin
            if (we0 && waddr0 != 0) begin m_mem[waddr0] = wdata0; m_busy[waddr0] = 1'b0; end
            if (we1 && waddr1 != 0) begin m_mem[waddr1] = wdata1; m_busy[waddr1] = 1'b0; end
            if (bset && baddr != 0) m_busy[baddr] = 1'b1;
        end
    end

    function automatic logic [31:0] m_read(input int a);
        if (a == 0) return 32'h0;
        if (!reset && we1 && waddr1 == a) return wdata1;
        if (!reset && we0 && waddr0 == a) return wdata0;
        return m_mem[a];
    endfunction

    function automatic logic m_rbusy(input int a);
        if (a == 0 || reset) return 1'b0;
        if ((we0 && waddr0 == a) || (we1 && waddr1 == a)) return 1'b0;
        return m_busy[a];
    endfunction

    always @(negedge clk) begin
        if (model_ok) begin
            for (int k = 0; k < 2; k++) begin
                int a;
                a = int'(raddr[k*5 +: 5]);
                checks++;
                if (rdata[k*32 +: 32] !== m_read(a)) begin
                    errors++;
                    $display("FAIL model_rdata%0d r%0d: got %h expected %h", k, a, rdata[k*32 +: 32], m_read(a));
                end
                checks++;
                if (rbusy[k] !== m_rbusy(a)) begin
                    errors++;
                    $display("FAIL model_rbusy%0d r%0d: got %b expected %b", k, a, rbusy[k], m_rbusy(a));
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic idle();
        we0 = 0; we1 = 0; bset = 0;
        waddr0 = 0; waddr1 = 0; baddr = 0;
        wdata0 = 0; wdata1 = 0;
        p_we0 = 0; p_we1 = 0; p_bset = 0;
        p_waddr0 = 0; p_waddr1 = 0; p_baddr = 0;
        p_wdata0 = 0; p_wdata1 = 0;
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    function automatic logic [15:0] pval(input int i);
        return 16'hA000 + 16'(i * 16'h0101);
    endfunction

    initial begin
        wpc0 = 32'h0000_1000; wpc1 = 32'h0000_1004;
        p_wpc0 = 32'h0; p_wpc1 = 32'h0; p_raddr = '0;
        idle();
        raddr = {5'd6, 5'd5};
        reset = 1'b1;
        adv(); adv();
        reset = 1'b0;
        settle();
        chk("reset_rdata0", rdata[31:0], 0);
        chk("reset_rbusy", rbusy, 0);
        adv();

        // r5 written, then reset together with a write and a bset
        we0 = 1; waddr0 = 5; wdata0 = 32'h1234;
        adv();
        idle();
        reset = 1; we0 = 1; waddr0 = 6; wdata0 = 32'hAAAA; bset = 1; baddr = 7;
        settle();
        chk("reset_shows_array", rdata[31:0], 32'h1234);
        chk("reset_no_bypass", rdata[63:32], 0);
        adv();
        idle(); reset = 0;
        raddr = {5'd7, 5'd5};
        settle();
        chk("reset_r5", rdata[31:0], 0);
        chk("reset_r7_busy", rbusy[1], 0);
        raddr = {5'd7, 5'd6};
        #1 chk("reset_r6", rdata[31:0], 0);
        adv();

        // same-cycle bypass then stored value
        we0 = 1; waddr0 = 3; wdata0 = 32'hDEADBEEF; raddr = {5'd0, 5'd3};
        settle();
        chk("bypass_same_cycle", rdata[31:0], 32'hDEADBEEF);
        adv();
        idle();
        settle();
        chk("bypass_stored", rdata[31:0], 32'hDEADBEEF);
        adv();

        // both ports to r4: port 1 wins
        we0 = 1; waddr0 = 4; wdata0 = 32'h11; we1 = 1; waddr1 = 4; wdata1 = 32'h22;
        raddr = {5'd4, 5'd3};
        settle();
        chk("conflict_bypass", rdata[63:32], 32'h22);
        adv();
        idle();
        settle();
        chk("conflict_stored", rdata[63:32], 32'h22);
        adv();

        // register 0 ignores writes and bset
        we1 = 1; waddr1 = 0; wdata1 = 32'hFFFFFFFF; bset = 1; baddr = 0; raddr = '0;
        settle();
        chk("r0_same_rdata", rdata, 0);
        chk("r0_same_rbusy", rbusy, 0);
        adv();
        idle();
        settle();
        chk("r0_next_rdata", rdata, 0);
        chk("r0_next_rbusy", rbusy, 0);
        adv();

        // scoreboard set, clear by write, then set/clear race
        bset = 1; baddr = 9; raddr = {5'd4, 5'd9};
        settle();
        chk("busy_not_yet", rbusy[0], 0);
        adv();
        idle();
        settle();
        chk("busy_set", rbusy[0], 1);
        adv();
        settle();
        chk("busy_held", rbusy[0], 1);
        adv();
        we0 = 1; waddr0 = 9; wdata0 = 32'h55;
        settle();
        chk("busy_clear_same", rbusy[0], 0);
        chk("busy_clear_data", rdata[31:0], 32'h55);
        adv();
        idle();
        settle();
        chk("busy_cleared", rbusy[0], 0);
        adv();
        bset = 1; baddr = 9; we0 = 1; waddr0 = 9; wdata0 = 32'h55;
        settle();
        chk("race_same", rbusy[0], 0);
        adv();
        idle();
        settle();
        chk("race_busy", rbusy[0], 1);
        chk("race_data", rdata[31:0], 32'h55);
        adv();
        // port 1 retires r9 while port 0 writes elsewhere
        we1 = 1; waddr1 = 9; wdata1 = 32'h77; we0 = 1; waddr0 = 12; wdata0 = 32'h99;
        raddr = {5'd12, 5'd9};
        adv();
        idle();
        settle();
        chk("p1_clear_busy", rbusy, 0);
        chk("p1_data", rdata, {32'h99, 32'h77});
        adv();

        // directed sweep of writes across the array, read back by the model checker
        for (int i = 1; i < 32; i++) begin
            we0 = 1; waddr0 = 5'(i); wdata0 = 32'hC0DE_0000 + 32'(i);
            we1 = (i % 3 == 0); waddr1 = 5'(i); wdata1 = 32'hB0B0_0000 + 32'(i);
            bset = (i % 4 == 0); baddr = 5'(32 - i);
            raddr = {5'(32 - i), 5'(i)};
            adv();
        end
        idle();
        for (int i = 0; i < 32; i += 2) begin
            raddr = {5'(i + 1), 5'(i)};
            adv();
        end

        // narrow build: 3 read ports, 16-bit data, 8 registers
        for (int i = 1; i < 8; i += 2) begin
            p_we0 = 1; p_waddr0 = 3'(i); p_wdata0 = pval(i);
            p_we1 = (i + 1 < 8); p_waddr1 = 3'(i + 1); p_wdata1 = pval(i + 1);
            adv();
        end
        idle();
        p_raddr = {3'd3, 3'd2, 3'd1};
        settle();
        chk("param_123", p_rdata, {pval(3), pval(2), pval(1)});
        p_raddr = {3'd6, 3'd5, 3'd4};
        #1 chk("param_456", p_rdata, {pval(6), pval(5), pval(4)});
        p_raddr = {3'd1, 3'd0, 3'd7};
        #1 chk("param_70", p_rdata, {pval(1), 16'h0, pval(7)});
        chk("param_rbusy", p_rbusy, 0);
        adv();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/grf_mp.md
Name: grf_mp

Overview:
- Parametrised multi-port general register file; successor to the single-write, two-read GRF in the CPU datapath.
- Adds:
  - a configurable number of read ports;
  - two write ports (port 0 = older stage, port 1 = younger stage);
  - internal write-to-read bypass;
  - a per-register busy scoreboard that the decode stage uses for hazard detection.
- Sits between decode (reads, busy queries, busy marking) and writeback (writes).

Parameters:
- DATA_W, 32, width of each register.
- ADDR_W, 5, register address width; depth = 2**ADDR_W.
- NUM_RD, 2, number of read ports (minimum 1).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- raddr  input  NUM_RD*ADDR_W  read addresses; port k at bits [k*ADDR_W +: ADDR_W].
- rdata  output  NUM_RD*DATA_W  read data; port k at bits [k*DATA_W +: DATA_W].
- rbusy  output  NUM_RD  per-read-port busy flag for the addressed register.
- we0  input  1  write enable, port 0.
- waddr0  input  ADDR_W  write address, port 0.
- wdata0  input  DATA_W  write data, port 0.
- wpc0  input  32  PC of the instruction writing through port 0 (trace only).
- we1  input  1  write enable, port 1.
- waddr1  input  ADDR_W  write address, port 1.
- wdata1  input  DATA_W  write data, port 1.
- wpc1  input  32  PC of the instruction writing through port 1 (trace only).
- bset  input  1  mark a register busy (producer issued).
- baddr  input  ADDR_W  register to mark busy.

Behaviour:
- **Register 0**
  - Always reads 0 and is never busy.
  - Writes and bset targeting address 0 are ignored.
- **Reset**
  - On a rising edge with reset=1, every register clears to 0 and every busy bit clears to 0.
  - Reset overrides any write or bset in the same cycle.
  - While reset=1, bypass and rbusy are suppressed: rdata shows array contents, rbusy=0.
- **Write**
  - On a rising edge with reset=0, weX=1 and waddrX!=0, the register takes wdataX.
  - Port 0 and port 1 to the same address in the same cycle: port 1 wins; port 0's write is dropped.
- **Read**
  - Purely combinational, zero latency.
  - Bypass priority for read port k, evaluated with reset=0 and raddr[k]!=0:
    1. we1 && waddr1==raddr[k] → rdata[k]=wdata1;
    2. else we0 && waddr0==raddr[k] → rdata[k]=wdata0;
    3. else the stored value.
  - Read-after-write therefore gives 0-cycle visibility of the write in progress.
- **Busy scoreboard**
  - One bit per register.
  - Next-state per register r:
    - set if bset && baddr==r;
    - else cleared if (we0 && waddr0==r) || (we1 && waddr1==r);
    - else held.
  - bset and a write to the same register in the same cycle: the set wins (a new producer supersedes the retiring one).
  - rbusy[k] = busy[raddr[k]] && !(write to raddr[k] this cycle) && raddr[k]!=0.
  - This is bypass-consistent: data arriving this cycle is not busy.
  - bset does not affect rbusy combinationally; it is visible from the next cycle.
- **Widths**
  - No arithmetic.
  - Address comparisons are exact ADDR_W-bit; all outputs are fully driven for every parameter set.

Optional Feature:
- Macro: GRF_TRACE_EN.
- **Defined:** on each rising edge with reset=0, print one $display line per committed write, port 0 first then port 1, in the form "@%h: $%d <= %h" with wpcX, waddrX, wdataX.
  - Port 0 writes dropped by a same-address port 1 write are not printed.
  - Writes to register 0 are not printed.
- **Undefined:** no display statements are compiled; functional behaviour is identical.

Test Plan:
- **Reset:** write 0x1234 to r5, then assert reset for one cycle together with we0 to r6 and bset to r7 → afterwards r5=r6=0, rbusy for r7=0.
- **Basic/bypass:** we0, waddr0=3, wdata0=0xDEADBEEF with raddr port0=3 in the same cycle → rdata0=0xDEADBEEF combinationally; next cycle, with we0=0, still 0xDEADBEEF.
- **Dual write conflict:** we0 (r4, 0x11) and we1 (r4, 0x22) in the same cycle → same-cycle bypass read=0x22; stored r4=0x22; with GRF_TRACE_EN only the port 1 line is printed.
- **Register 0:** we1 to r0 with 0xFFFFFFFF plus bset baddr=0 → rdata=0 and rbusy=0 on both the same and the next cycle.
- **Scoreboard set/clear race:** bset r9 at cycle N → rbusy=1 from N+1. At cycle M, we0 to r9 (0x55) with no bset → rbusy=0 in cycle M (bypass-consistent) and stays 0 from M+1. Repeat with bset r9 and we0 r9 in the same cycle → rbusy=1 afterwards and rdata=0x55.
- **Parametrisation:** NUM_RD=3, DATA_W=16, ADDR_W=3; write distinct values to r1..r7, read three ports simultaneously → each port returns its own register; r0=0.
